frontend_ovf_mon: RTL and testbench

FRONTEND_OVF_MON -- requirements
Module: frontend_ovf_mon

---
 rtl/frontend_ovf_mon.sv | 136 +++++++++++++
 tb/tb_frontend_ovf_mon.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_ovf_mon.sv
// rtl/frontend_ovf_mon.sv - per-channel ADC overflow window counter with alarm and sticky flags
module frontend_ovf_mon #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run_0,
  input  logic        run_1,
  input  logic        adc_ovf_i_0,
  input  logic        adc_ovf_q_0,
  input  logic        adc_ovf_i_1,
  input  logic        adc_ovf_q_1,
  output logic [15:0] ovf_count_0,
  output logic [15:0] ovf_count_1,
  output logic        ovf_alarm_0,
  output logic        ovf_alarm_1,
  output logic        ovf_sticky_0,
  output logic        ovf_sticky_1,
  output logic [31:0] status
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  logic [23:0] win_len;
  logic [15:0] thr;
  logic        enable;
  logic        wr_win, wr_thr, wr_ctrl, clr;
  logic [1:0]  run, ovf;
  logic        unused_data;

  assign wr_win      = set_stb && (set_addr == BASE);
  assign wr_thr      = set_stb && (set_addr == BASE + 8'd1);
  assign wr_ctrl     = set_stb && (set_addr == BASE + 8'd2);
  assign clr         = wr_ctrl && set_data[1];
  assign unused_data = ^set_data[31:24];

  assign run = {run_1, run_0};
  assign ovf = {adc_ovf_i_1 | adc_ovf_q_1, adc_ovf_i_0 | adc_ovf_q_0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len <= '0;
      thr     <= '0;
      enable  <= 1'b0;
    end else begin
      if (wr_win)  win_len <= set_data[23:0];
      if (wr_thr)  thr     <= set_data[15:0];
      if (wr_ctrl) enable  <= set_data[0];
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [0:0]  state;
    logic [23:0] win_cnt;
    logic [15:0] ev_cnt;
    logic [15:0] count_q;
    logic        alarm_q;
    logic        sticky_q;
    logic        start_ok, in_win, final_cyc, latch, alarm_new;
    logic [23:0] rem;
    logic [15:0] acc, sum;
    logic [16:0] sum_w;

    // From IDLE the current cycle is the window's entry cycle, so it counts
    // from win_len; in COUNT win_cnt holds the cycles left including this one.
    always_comb begin
      start_ok = enable && run[ch] && (win_len != 24'd0);
      if (state == ST_IDLE) begin
        in_win = start_ok;
        rem    = win_len;
        acc    = '0;
      end else begin
        in_win = enable && run[ch];
        rem    = win_cnt;
        acc    = ev_cnt;
      end
      sum_w     = {1'b0, acc} + {16'd0, ovf[ch]};
      sum       = sum_w[16] ? 16'hFFFF : sum_w[15:0];
      final_cyc = (rem == 24'd1);
      latch     = in_win && final_cyc;
      alarm_new = (thr != 16'd0) && (sum >= thr);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        win_cnt  <= '0;
        ev_cnt   <= '0;
        count_q  <= '0;
        alarm_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        if (!in_win) begin
          state   <= ST_IDLE;
          win_cnt <= '0;
          ev_cnt  <= '0;
        end else if (final_cyc) begin
          // Reloading here makes the next cycle the entry of a new window.
          state   <= start_ok ? ST_COUNT : ST_IDLE;
          win_cnt <= start_ok ? win_len : 24'd0;
          ev_cnt  <= '0;
        end else begin
          state   <= ST_COUNT;
          win_cnt <= rem - 24'd1;
          ev_cnt  <= sum;
        end

        if (latch) begin
          count_q <= sum;
          alarm_q <= alarm_new;
        end else if (clr) begin
          count_q <= '0;
          alarm_q <= 1'b0;
        end

        if (latch && alarm_new) sticky_q <= 1'b1;
        else if (clr)           sticky_q <= 1'b0;
      end
    end
  end

  assign ovf_count_0  = g_ch[0].count_q;
  assign ovf_count_1  = g_ch[1].count_q;
  assign ovf_alarm_0  = g_ch[0].alarm_q;
  assign ovf_alarm_1  = g_ch[1].alarm_q;
  assign ovf_sticky_0 = g_ch[0].sticky_q;
  assign ovf_sticky_1 = g_ch[1].sticky_q;

  assign status = {g_ch[1].sticky_q, g_ch[1].alarm_q, g_ch[0].sticky_q, g_ch[0].alarm_q,
                   10'd0, g_ch[1].state == ST_COUNT, g_ch[0].state == ST_COUNT, 16'd0};

endmodule

// File: tb/tb_frontend_ovf_mon.sv
// tb/tb_frontend_ovf_mon.sv - self-checking bench for frontend_ovf_mon
module tb_frontend_ovf_mon;
  localparam logic [7:0] BASE = 8'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        run_0 = 1'b0, run_1 = 1'b0;
  logic        adc_ovf_i_0 = 1'b0, adc_ovf_q_0 = 1'b0, adc_ovf_i_1 = 1'b0, adc_ovf_q_1 = 1'b0;
  logic [15:0] ovf_count_0, ovf_count_1;
  logic        ovf_alarm_0, ovf_alarm_1, ovf_sticky_0, ovf_sticky_1;
  logic [31:0] status;

  frontend_ovf_mon #(.BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .run_0(run_0), .run_1(run_1),
    .adc_ovf_i_0(adc_ovf_i_0), .adc_ovf_q_0(adc_ovf_q_0),
    .adc_ovf_i_1(adc_ovf_i_1), .adc_ovf_q_1(adc_ovf_q_1),
    .ovf_count_0(ovf_count_0), .ovf_count_1(ovf_count_1),
    .ovf_alarm_0(ovf_alarm_0), .ovf_alarm_1(ovf_alarm_1),
    .ovf_sticky_0(ovf_sticky_0), .ovf_sticky_1(ovf_sticky_1),
    .status(status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is a list of cycles counted up from 1 to its length.
  int r_win, r_thr;
  bit r_en;
  bit m_act[2], m_alarm[2], m_sticky[2], m_run[2], m_ovf[2];
  int m_n[2], m_wl[2], m_cnt[2], m_count[2];
  bit m_clr, m_lat;

  always @(posedge clk) begin
    if (!rst_n) begin
      r_win = 0; r_thr = 0; r_en = 0;
      for (int c = 0; c < 2; c++) begin
        m_act[c] = 0; m_n[c] = 0; m_wl[c] = 0; m_cnt[c] = 0;
        m_count[c] = 0; m_alarm[c] = 0; m_sticky[c] = 0;
      end
    end else begin
      m_clr = set_stb && (set_addr == BASE + 8'd2) && set_data[1];
      m_run[0] = run_0; m_run[1] = run_1;
      m_ovf[0] = adc_ovf_i_0 | adc_ovf_q_0;
      m_ovf[1] = adc_ovf_i_1 | adc_ovf_q_1;
      for (int c = 0; c < 2; c++) begin
        m_lat = 0;
        if (!m_act[c] && r_en && m_run[c] && r_win != 0) begin
          m_act[c] = 1; m_wl[c] = r_win; m_n[c] = 0; m_cnt[c] = 0;
        end else if (m_act[c] && !(r_en && m_run[c])) begin
          m_act[c] = 0;
        end
        if (m_act[c]) begin
          m_n[c]++;
          m_cnt[c] = m_cnt[c] + int'(m_ovf[c]);
          if (m_cnt[c] > 65535) m_cnt[c] = 65535;
          if (m_n[c] == m_wl[c]) begin
            m_lat = 1;
            m_count[c] = m_cnt[c];
            m_alarm[c] = (r_thr != 0) && (m_cnt[c] >= r_thr);
            if (m_alarm[c]) m_sticky[c] = 1;
            m_act[c] = 0;
            if (r_en && m_run[c] && r_win != 0) begin
              m_act[c] = 1; m_wl[c] = r_win; m_n[c] = 0; m_cnt[c] = 0;
            end
          end
        end
        if (m_clr && !m_lat) begin m_count[c] = 0; m_alarm[c] = 0; end
        if (m_clr && !(m_lat && m_alarm[c])) m_sticky[c] = 0;
      end
      if (set_stb && set_addr == BASE)         r_win = int'(set_data[23:0]);
      if (set_stb && set_addr == BASE + 8'd1)  r_thr = int'(set_data[15:0]);
      if (set_stb && set_addr == BASE + 8'd2)  r_en  = set_data[0];
    end
  end

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("mdl_count0", {16'd0, ovf_count_0}, m_count[0]);
      check("mdl_count1", {16'd0, ovf_count_1}, m_count[1]);
      check("mdl_alarm0", {31'd0, ovf_alarm_0}, {31'd0, m_alarm[0]});
      check("mdl_alarm1", {31'd0, ovf_alarm_1}, {31'd0, m_alarm[1]});
      check("mdl_sticky0", {31'd0, ovf_sticky_0}, {31'd0, m_sticky[0]});
      check("mdl_sticky1", {31'd0, ovf_sticky_1}, {31'd0, m_sticky[1]});
      check("mdl_status", status, {m_sticky[1], m_alarm[1], m_sticky[0], m_alarm[0],
                                   10'd0, m_act[1], m_act[0], 16'd0});
    end
  end

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = BASE + off;
    set_data = data;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_status", status, 32'h0);
    check("rst_count0", {16'd0, ovf_count_0}, 32'h0);
    rst_n = 1'b1;
    wr(8'd3, 32'hFFFF_FFFF);

    // 8-cycle window, three overflow cycles, threshold 3
    run_0 = 1'b1;
    wr(8'd0, 32'd8);
    wr(8'd1, 32'd3);
    wr(8'd2, 32'd1);
    @(negedge clk);
    adc_ovf_i_0 = 1'b1;
    repeat (3) @(negedge clk);
    adc_ovf_i_0 = 1'b0;
    repeat (4) @(negedge clk);
    check("w8_count0", {16'd0, ovf_count_0}, 32'd3);
    check("w8_alarm0", {31'd0, ovf_alarm_0}, 32'd1);
    check("w8_sticky0", {31'd0, ovf_sticky_0}, 32'd1);
    wr(8'd2, 32'd0);
    run_0 = 1'b0;

    // back-to-back 4-cycle windows on channel 1
    wr(8'd0, 32'd4);
    wr(8'd1, 32'd5);
    run_1 = 1'b1;
    adc_ovf_q_1 = 1'b1;
    wr(8'd2, 32'd1);
    repeat (4) @(negedge clk);
    check("b2b_count1", {16'd0, ovf_count_1}, 32'd4);
    check("b2b_alarm1", {31'd0, ovf_alarm_1}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b_busy1", {31'd0, status[17]}, 32'd1);
    end
    adc_ovf_q_1 = 1'b0;
    run_1 = 1'b0;
    wr(8'd2, 32'd0);

    // abort mid-window keeps previous result
    wr(8'd0, 32'd8);
    wr(8'd1, 32'd3);
    run_0 = 1'b1;
    adc_ovf_i_0 = 1'b1;
    wr(8'd2, 32'd1);
    repeat (12) @(negedge clk);
    run_0 = 1'b0;
    @(negedge clk);
    check("abort_busy0", {31'd0, status[16]}, 32'd0);
    check("abort_count0", {16'd0, ovf_count_0}, 32'd8);
    repeat (3) @(negedge clk);
    check("abort_hold0", {16'd0, ovf_count_0}, 32'd8);

    // clear alone
    adc_ovf_i_0 = 1'b0;
    wr(8'd2, 32'd2);
    check("clr_count0", {16'd0, ovf_count_0}, 32'd0);
    check("clr_alarm0", {31'd0, ovf_alarm_0}, 32'd0);
    check("clr_sticky0", {31'd0, ovf_sticky_0}, 32'd0);

    // clear coincident with alarm-setting latch
    wr(8'd0, 32'd4);
    wr(8'd1, 32'd2);
    run_0 = 1'b1;
    adc_ovf_i_0 = 1'b1;
    wr(8'd2, 32'd1);
    repeat (3) @(negedge clk);
    wr(8'd2, 32'd3);
    check("clrlat_sticky0", {31'd0, ovf_sticky_0}, 32'd1);
    check("clrlat_count0", {16'd0, ovf_count_0}, 32'd4);
    check("clrlat_alarm0", {31'd0, ovf_alarm_0}, 32'd1);

    // reset mid-window with sticky set
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_status", status, 32'h0);
    check("rst2_count0", {16'd0, ovf_count_0}, 32'd0);
    check("rst2_sticky0", {31'd0, ovf_sticky_0}, 32'd0);
    rst_n = 1'b1;

    // win_len=0 holds idle; then thr=0 and a mid-window win_len change
    wr(8'd1, 32'd2);
    wr(8'd2, 32'd1);
    repeat (5) @(negedge clk);
    check("wl0_status", status, 32'h0);
    wr(8'd1, 32'd0);
    wr(8'd0, 32'd6);
    wr(8'd0, 32'd3);
    repeat (5) @(negedge clk);
    check("wlchg_count0", {16'd0, ovf_count_0}, 32'd6);
    check("thr0_alarm0", {31'd0, ovf_alarm_0}, 32'd0);
    repeat (3) @(negedge clk);
    check("wlnew_count0", {16'd0, ovf_count_0}, 32'd3);
    check("thr0_sticky0", {31'd0, ovf_sticky_0}, 32'd0);
    wr(8'd2, 32'd0);
    run_0 = 1'b0;
    adc_ovf_i_0 = 1'b0;

    // saturation over a window longer than 65535 cycles
    wr(8'd0, 32'd65600);
    wr(8'd1, 32'h0000_FFFF);
    run_1 = 1'b1;
    adc_ovf_i_1 = 1'b1;
    wr(8'd2, 32'd1);
    repeat (65599) @(negedge clk);
    check("sat_pre_count1", {16'd0, ovf_count_1}, 32'd0);
    @(negedge clk);
    check("sat_count1", {16'd0, ovf_count_1}, 32'h0000_FFFF);
    check("sat_alarm1", {31'd0, ovf_alarm_1}, 32'd1);
    check("sat_sticky1", {31'd0, ovf_sticky_1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
